// File: rtl/elbeth_forward_unit_pkg.sv
// Shared definitions for the ELBETH forwarding / hazard unit.
// Holds the operand-select encodings driven onto the EX-stage operand
// muxes and the field widths of the per-stage pipeline records.
package elbeth_forward_unit_pkg;

    // Operand-select encodings for the EX-stage 3-to-1 operand muxes.
    localparam logic [1:0] SEL_REG = 2'b00;  // register-file value
    localparam logic [1:0] SEL_MEM = 2'b01;  // MEM-stage ALU result
    localparam logic [1:0] SEL_WB  = 2'b10;  // WB-stage result

    // Stage-record field widths.
    localparam int unsigned REG_IDX_W = 5;   // register index
    localparam int unsigned SEL_W     = 2;   // operand-select code

endpackage

// File: rtl/elbeth_fwd_cmp.sv
// Per-operand forwarding comparator.
// Chooses the select code for one EX-stage source register by comparing it
// against the MEM and WB stage destination records; MEM is younger and wins.
// Ports:
//   ex_valid               - EX stage holds a real instruction
//   rs                     - EX source register index
//   mem_valid/mem_we/mem_rd - MEM stage record (mem_we already excludes loads)
//   wb_valid/wb_we/wb_rd    - WB stage record
//   sel                    - select code (SEL_REG / SEL_MEM / SEL_WB)
module elbeth_fwd_cmp
    import elbeth_forward_unit_pkg::*;
#(
    parameter int XLEN_REGS = REG_IDX_W
) (
    input  logic                 ex_valid,
    input  logic [XLEN_REGS-1:0] rs,
    input  logic                 mem_valid,
    input  logic                 mem_we,
    input  logic [XLEN_REGS-1:0] mem_rd,
    input  logic                 wb_valid,
    input  logic                 wb_we,
    input  logic [XLEN_REGS-1:0] wb_rd,
    output logic [SEL_W-1:0]     sel
);

    logic mem_hit_s;
    logic wb_hit_s;

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    assign mem_hit_s = mem_valid & mem_we & (mem_rd != '0) & (mem_rd == rs);
    assign wb_hit_s  = wb_valid & wb_we & (wb_rd != '0) & (wb_rd == rs);

    // Priority select: youngest producer first, register file otherwise.
    always_comb begin
        sel = SEL_REG;
        if (ex_valid && mem_hit_s) begin
            sel = SEL_MEM;
        end else if (ex_valid && wb_hit_s) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_REG;
        end
    end

endmodule

// File: rtl/elbeth_forward_unit.sv
// ELBETH forwarding and load-use hazard unit.
// Tracks EX/MEM/WB stage records, produces operand-select codes for the
// EX-stage operands, detects load-use hazards (one-cycle stall) and counts
// stall cycles with saturation.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   issue_*                 - instruction leaving ID into EX this cycle
//   flush                   - taken branch/jump; kills issue and EX
//   fwd_a_sel / fwd_b_sel   - select codes for rs1 / rs2 operand muxes
//   stall                   - load-use hazard, ID holds and retries
//   stall_count             - saturating count of stall cycles
module elbeth_forward_unit
    import elbeth_forward_unit_pkg::*;
#(
    parameter int XLEN_REGS = REG_IDX_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [XLEN_REGS-1:0] issue_rs1,
    input  logic [XLEN_REGS-1:0] issue_rs2,
    input  logic [XLEN_REGS-1:0] issue_rd,
    input  logic                 issue_reg_write,
    input  logic                 issue_mem_read,
    input  logic                 flush,
    output logic [SEL_W-1:0]     fwd_a_sel,
    output logic [SEL_W-1:0]     fwd_b_sel,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_count
);

    // EX stage record
    logic                 ex_valid_q, ex_valid_d;
    logic [XLEN_REGS-1:0] ex_rs1_q, ex_rs1_d;
    logic [XLEN_REGS-1:0] ex_rs2_q, ex_rs2_d;
    logic [XLEN_REGS-1:0] ex_rd_q, ex_rd_d;
    logic                 ex_we_q, ex_we_d;
    logic                 ex_mr_q, ex_mr_d;
    // MEM stage record
    logic                 mem_valid_q, mem_valid_d;
    logic [XLEN_REGS-1:0] mem_rd_q, mem_rd_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_mr_q, mem_mr_d;
    // WB stage record
    logic                 wb_valid_q, wb_valid_d;
    logic [XLEN_REGS-1:0] wb_rd_q, wb_rd_d;
    logic                 wb_we_q, wb_we_d;
    // Stall counter
    logic [CNT_W-1:0]     stall_count_q, stall_count_d;

    logic                 stall_s;
    logic                 mem_alu_we_s;

    // Load-use hazard: EX holds a load whose result the issuing op needs.
    always_comb begin
        stall_s = 1'b0;
        if (issue_valid && !flush && ex_valid_q && ex_mr_q && ex_we_q &&
            (ex_rd_q != '0) &&
            ((ex_rd_q == issue_rs1) || (ex_rd_q == issue_rs2))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // A load in MEM has no ALU result to forward; the stall keeps any
    // dependent instruction out of EX while the load sits there.
    assign mem_alu_we_s = mem_we_q & ~mem_mr_q;

    // Next-state for the stage records and the saturating stall counter.
    always_comb begin
        // EX takes the issuing instruction unless it is stalled or flushed.
        ex_valid_d = issue_valid & ~stall_s & ~flush;
        ex_rs1_d   = issue_rs1;
        ex_rs2_d   = issue_rs2;
        ex_rd_d    = issue_rd;
        ex_we_d    = issue_reg_write;
        ex_mr_d    = issue_mem_read;
        // MEM and WB always advance, even on stall or flush.
        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_we_d    = ex_we_q;
        mem_mr_d    = ex_mr_q;
        wb_valid_d  = mem_valid_q;
        wb_rd_d     = mem_rd_q;
        wb_we_d     = mem_we_q;
        stall_count_d = stall_count_q;
        if (stall_s && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stage registers; reset discards every in-flight record.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_we_q       <= 1'b0;
            ex_mr_q       <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_mr_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_we_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_we_q       <= ex_we_d;
            ex_mr_q       <= ex_mr_d;
            mem_valid_q   <= mem_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_we_q      <= mem_we_d;
            mem_mr_q      <= mem_mr_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_we_q       <= wb_we_d;
            stall_count_q <= stall_count_d;
        end
    end

    elbeth_fwd_cmp #(.XLEN_REGS(XLEN_REGS)) u_cmp_a (
        .ex_valid  (ex_valid_q),
        .rs        (ex_rs1_q),
        .mem_valid (mem_valid_q),
        .mem_we    (mem_alu_we_s),
        .mem_rd    (mem_rd_q),
        .wb_valid  (wb_valid_q),
        .wb_we     (wb_we_q),
        .wb_rd     (wb_rd_q),
        .sel       (fwd_a_sel)
    );

    elbeth_fwd_cmp #(.XLEN_REGS(XLEN_REGS)) u_cmp_b (
        .ex_valid  (ex_valid_q),
        .rs        (ex_rs2_q),
        .mem_valid (mem_valid_q),
        .mem_we    (mem_alu_we_s),
        .mem_rd    (mem_rd_q),
        .wb_valid  (wb_valid_q),
        .wb_we     (wb_we_q),
        .wb_rd     (wb_rd_q),
        .sel       (fwd_b_sel)
    );

    assign stall       = stall_s;
    assign stall_count = stall_count_q;

endmodule
